// File: rtl/uart_pkg.sv
// Shared constants for the UART baud generator: oversampling ratios,
// RX bit-phase state encoding and the default fractional-divisor width.
package uart_pkg;

    localparam int FRAC_W_DEF = 4;

    localparam logic [4:0] OVS16 = 5'd16;
    localparam logic [4:0] OVS8  = 5'd8;

    localparam logic [1:0] RX_IDLE = 2'b00;
    localparam logic [1:0] RX_HALF = 2'b01;
    localparam logic [1:0] RX_FULL = 2'b10;

    // Last oversample index of a full bit (OVS-1).
    function automatic logic [3:0] ovs_last(input logic sel);
        logic [4:0] v_ovs;
        v_ovs = sel ? OVS8 : OVS16;
        v_ovs = v_ovs - 5'd1;
        return v_ovs[3:0];
    endfunction

    // Last oversample index of a half bit (OVS/2-1), i.e. the mid-bit point.
    function automatic logic [3:0] ovs_mid_last(input logic sel);
        logic [4:0] v_ovs;
        v_ovs = sel ? OVS8 : OVS16;
        v_ovs = (v_ovs >> 3'd1) - 5'd1;
        return v_ovs[3:0];
    endfunction

endpackage

// File: rtl/uart_rx_phase.sv
// RX bit-phase tracker: after a start-bit restart it strobes mid-bit once
// half a bit has elapsed, then once per full bit until the next restart.
module uart_rx_phase
    import uart_pkg::*;
(
    input  logic PCLK,
    input  logic PRESETN,
    input  logic clr,
    input  logic tick,
    input  logic ovs_sel,
    input  logic rx_restart,
    output logic rx_bit_pulse
);

    logic [1:0] r_state;
    logic [3:0] r_rx_cnt;
    logic       w_mid;
    logic       w_last;
    logic       w_hit;
    logic       w_pulse;

    assign w_mid  = (r_rx_cnt == ovs_mid_last(ovs_sel));
    assign w_last = (r_rx_cnt == ovs_last(ovs_sel));

    // Strobe decode; a restart or clear in the same cycle suppresses it.
    always_comb begin
        w_hit   = 1'b0;
        w_pulse = 1'b0;
        case (r_state)
            RX_HALF: w_hit = w_mid;
            RX_FULL: w_hit = w_last;
            default: w_hit = 1'b0;
        endcase
        if (clr || rx_restart) begin
            w_pulse = 1'b0;
        end else begin
            w_pulse = tick && w_hit;
        end
    end

    assign rx_bit_pulse = w_pulse;

    // Phase state and oversample counter; clear beats restart beats ticks.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state  <= RX_IDLE;
            r_rx_cnt <= 4'd0;
        end else if (clr) begin
            r_state  <= RX_IDLE;
            r_rx_cnt <= 4'd0;
        end else if (rx_restart) begin
            r_state  <= RX_HALF;
            r_rx_cnt <= 4'd0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    r_state  <= RX_IDLE;
                    r_rx_cnt <= 4'd0;
                end
                RX_HALF: begin
                    if (tick && w_mid) begin
                        r_state  <= RX_FULL;
                        r_rx_cnt <= 4'd0;
                    end else if (tick) begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt;
                    end
                end
                RX_FULL: begin
                    if (tick && w_last) begin
                        r_rx_cnt <= 4'd0;
                    end else if (tick) begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt;
                    end
                end
                default: begin
                    r_state  <= RX_IDLE;
                    r_rx_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: prescaler, TX bit counter and RX bit-phase tracker.
// Define UART_BAUD_FRAC_EN to enable the fractional-divisor accumulator.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CNT_W  = 13,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              en,
    input  logic [CNT_W-1:0]  baud_int,
    input  logic [FRAC_W-1:0] baud_frac,
    input  logic              ovs_sel,
    input  logic              rx_restart,
    output logic              rx_sample_pulse,
    output logic              tx_baud_pulse,
    output logic              rx_bit_pulse
);

    logic [CNT_W-1:0] r_baud_int;
    logic             r_ovs_sel;
    logic [CNT_W:0]   r_cnt;
    logic [3:0]       r_tx_cnt;
    logic [CNT_W:0]   w_term;
    logic             w_cfg_chg;
    logic             w_clr;
    logic             w_tick;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_baud_frac;
    logic [FRAC_W-1:0] r_acc;
    logic              r_stretch;
    logic [FRAC_W:0]   w_sum;
    logic [FRAC_W:0]   w_sum_next;

    assign w_cfg_chg = (baud_int != r_baud_int) || (baud_frac != r_baud_frac)
                    || (ovs_sel != r_ovs_sel);
    assign w_term    = {1'b0, r_baud_int} + {{CNT_W{1'b0}}, r_stretch};

    // stretch holds the carry of the accumulation that the coming period
    // completes, so a period is lengthened in the same period the carry occurs.
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_baud_frac};
    assign w_sum_next = {1'b0, w_sum[FRAC_W-1:0]} + {1'b0, r_baud_frac};

    // Fractional shadow, accumulator and period stretch.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_baud_frac <= {FRAC_W{1'b0}};
            r_acc       <= {FRAC_W{1'b0}};
            r_stretch   <= 1'b0;
        end else begin
            r_baud_frac <= baud_frac;
            if (w_clr) begin
                r_acc     <= {FRAC_W{1'b0}};
                r_stretch <= 1'b0;
            end else if (w_tick) begin
                r_acc     <= w_sum[FRAC_W-1:0];
                r_stretch <= w_sum_next[FRAC_W];
            end else begin
                r_acc     <= r_acc;
                r_stretch <= r_stretch;
            end
        end
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^baud_frac;
    assign w_cfg_chg     = (baud_int != r_baud_int) || (ovs_sel != r_ovs_sel);
    assign w_term        = {1'b0, r_baud_int};
`endif

    assign w_clr  = !en || w_cfg_chg;
    assign w_tick = PRESETN && en && !w_cfg_chg && (r_cnt == w_term);

    assign rx_sample_pulse = w_tick;
    assign tx_baud_pulse   = w_tick && (r_tx_cnt == ovs_last(r_ovs_sel));

    // Configuration shadows sampled every cycle for change detection.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_baud_int <= {CNT_W{1'b0}};
            r_ovs_sel  <= 1'b0;
        end else begin
            r_baud_int <= baud_int;
            r_ovs_sel  <= ovs_sel;
        end
    end

    // Prescaler: counts 0..term then wraps.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_cnt <= {(CNT_W+1){1'b0}};
        end else if (w_clr || w_tick) begin
            r_cnt <= {(CNT_W+1){1'b0}};
        end else begin
            r_cnt <= r_cnt + {{CNT_W{1'b0}}, 1'b1};
        end
    end

    // TX oversample counter, wraps after OVS ticks.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_tx_cnt <= 4'd0;
        end else if (w_clr) begin
            r_tx_cnt <= 4'd0;
        end else if (w_tick && (r_tx_cnt == ovs_last(r_ovs_sel))) begin
            r_tx_cnt <= 4'd0;
        end else if (w_tick) begin
            r_tx_cnt <= r_tx_cnt + 4'd1;
        end else begin
            r_tx_cnt <= r_tx_cnt;
        end
    end

    uart_rx_phase u_rx_phase (
        .PCLK         (PCLK),
        .PRESETN      (PRESETN),
        .clr          (w_clr),
        .tick         (w_tick),
        .ovs_sel      (r_ovs_sel),
        .rx_restart   (rx_restart),
        .rx_bit_pulse (rx_bit_pulse)
    );

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed self-checking bench for uart_baud_gen (default and
// UART_BAUD_FRAC_EN builds).
module tb_uart_baud_gen;

    localparam int CNT_W  = 13;
    localparam int FRAC_W = 4;

    logic              PCLK = 1'b0;
    logic              PRESETN;
    logic              en;
    logic [CNT_W-1:0]  baud_int;
    logic [FRAC_W-1:0] baud_frac;
    logic              ovs_sel;
    logic              rx_restart;
    logic              rx_sample_pulse;
    logic              tx_baud_pulse;
    logic              rx_bit_pulse;

    int   errors = 0;
    int   checks = 0;
    logic s_sp, s_tx, s_rx;

    uart_baud_gen #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
        .PCLK            (PCLK),
        .PRESETN         (PRESETN),
        .en              (en),
        .baud_int        (baud_int),
        .baud_frac       (baud_frac),
        .ovs_sel         (ovs_sel),
        .rx_restart      (rx_restart),
        .rx_sample_pulse (rx_sample_pulse),
        .tx_baud_pulse   (tx_baud_pulse),
        .rx_bit_pulse    (rx_bit_pulse)
    );

    always #5 PCLK = ~PCLK;

    // Sample the current cycle's outputs at the falling edge, then move to
    // just after the next rising edge where new inputs are applied.
    task automatic tick_cycle();
        @(negedge PCLK);
        s_sp = rx_sample_pulse;
        s_tx = tx_baud_pulse;
        s_rx = rx_bit_pulse;
        @(posedge PCLK);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    // Advance until the selected strobe (0=sample,1=tx,2=rx) is seen;
    // cyc counts cycles including the strobe cycle, -1 if the bound expired.
    task automatic wait_ev(input int sel, input int limit,
                           output int cyc, output int nsp, output int nrx);
        logic hit;
        hit = 1'b0; cyc = 0; nsp = 0; nrx = 0;
        while (!hit && cyc < limit) begin
            tick_cycle();
            cyc++;
            if (s_sp) nsp++;
            if (s_rx) nrx++;
            case (sel)
                0:       hit = s_sp;
                1:       hit = s_tx;
                default: hit = s_rx;
            endcase
        end
        if (!hit) cyc = -1;
    endtask

    task automatic test_reset();
        PRESETN = 1'b0; en = 1'b1; baud_int = '0; baud_frac = '0;
        ovs_sel = 1'b0; rx_restart = 1'b0;
        #3;
        checks++;
        if ({rx_sample_pulse, tx_baud_pulse, rx_bit_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000",
                     {rx_sample_pulse, tx_baud_pulse, rx_bit_pulse});
        end
        skip(2);
        checks++;
        if ({s_sp, s_tx, s_rx} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held: got %b expected 000", {s_sp, s_tx, s_rx});
        end
        PRESETN = 1'b1; en = 1'b0; baud_int = 13'd3;
        tick_cycle();
        en = 1'b1;
    endtask

    task automatic test_first_tick();
        int cyc, nsp, nrx;
        wait_ev(0, 50, cyc, nsp, nrx);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL first_tick: got %0d cycles expected 4", cyc);
        end
    endtask

    task automatic test_int_period();
        int cyc, nsp, nrx;
        for (int i = 0; i < 3; i++) begin
            wait_ev(0, 50, cyc, nsp, nrx);
            checks++;
            if (cyc !== 4) begin
                errors++;
                $display("FAIL sample_period[%0d]: got %0d expected 4", i, cyc);
            end
        end
        wait_ev(1, 200, cyc, nsp, nrx);
        wait_ev(1, 200, cyc, nsp, nrx);
        checks++;
        if (cyc !== 64 || nsp !== 16) begin
            errors++;
            $display("FAIL tx_period_16x: got %0d cycles %0d ticks expected 64/16", cyc, nsp);
        end
        checks++;
        if (nrx !== 0) begin
            errors++;
            $display("FAIL rx_idle_quiet: got %0d rx strobes expected 0", nrx);
        end
    endtask

    task automatic test_rx_restart();
        int cyc, nsp, nrx;
        rx_restart = 1'b1;
        tick_cycle();
        rx_restart = 1'b0;
        wait_ev(2, 200, cyc, nsp, nrx);
        checks++;
        if (cyc !== 31 || nsp !== 8) begin
            errors++;
            $display("FAIL rx_first_mid: got %0d cycles %0d ticks expected 31/8", cyc, nsp);
        end
        wait_ev(2, 200, cyc, nsp, nrx);
        checks++;
        if (cyc !== 64 || nsp !== 16) begin
            errors++;
            $display("FAIL rx_full_bit: got %0d cycles %0d ticks expected 64/16", cyc, nsp);
        end
        skip(63);
        rx_restart = 1'b1;
        tick_cycle();
        rx_restart = 1'b0;
        checks++;
        if (s_sp !== 1'b1 || s_rx !== 1'b0) begin
            errors++;
            $display("FAIL restart_on_tick: got sp=%b rx=%b expected sp=1 rx=0", s_sp, s_rx);
        end
        wait_ev(2, 200, cyc, nsp, nrx);
        checks++;
        if (cyc !== 32 || nsp !== 8) begin
            errors++;
            $display("FAIL rx_after_coincident: got %0d cycles %0d ticks expected 32/8", cyc, nsp);
        end
    endtask

    task automatic test_ovs_change();
        int cyc, nsp, nrx;
        skip(3);
        ovs_sel = 1'b1;
        tick_cycle();
        checks++;
        if (s_sp !== 1'b0) begin
            errors++;
            $display("FAIL ovs_change_no_tick: got %b expected 0", s_sp);
        end
        rx_restart = 1'b1;
        tick_cycle();
        rx_restart = 1'b0;
        wait_ev(2, 200, cyc, nsp, nrx);
        checks++;
        if (cyc !== 15 || nsp !== 4) begin
            errors++;
            $display("FAIL rx_mid_8x: got %0d cycles %0d ticks expected 15/4", cyc, nsp);
        end
        wait_ev(1, 200, cyc, nsp, nrx);
        checks++;
        if (cyc !== 16 || nsp !== 4) begin
            errors++;
            $display("FAIL tx_first_8x: got %0d cycles %0d ticks expected 16/4", cyc, nsp);
        end
        wait_ev(1, 200, cyc, nsp, nrx);
        checks++;
        if (cyc !== 32 || nsp !== 8) begin
            errors++;
            $display("FAIL tx_period_8x: got %0d cycles %0d ticks expected 32/8", cyc, nsp);
        end
    endtask

    task automatic test_en_low();
        int cyc, nsp, nrx;
        skip(2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_cycle();
            checks++;
            if ({s_sp, s_tx, s_rx} !== 3'b000) begin
                errors++;
                $display("FAIL en_low_outputs[%0d]: got %b expected 000", i, {s_sp, s_tx, s_rx});
            end
        end
        en = 1'b1;
        wait_ev(0, 50, cyc, nsp, nrx);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL en_resume_tick: got %0d cycles expected 4", cyc);
        end
    endtask

    task automatic test_div_one();
        int cyc, nsp, nrx;
        baud_int = 13'd0;
        tick_cycle();
        checks++;
        if (s_sp !== 1'b0) begin
            errors++;
            $display("FAIL div1_change_no_tick: got %b expected 0", s_sp);
        end
        for (int i = 0; i < 4; i++) begin
            tick_cycle();
            checks++;
            if (s_sp !== 1'b1) begin
                errors++;
                $display("FAIL div1_every_cycle[%0d]: got %b expected 1", i, s_sp);
            end
        end
        wait_ev(1, 50, cyc, nsp, nrx);
        wait_ev(1, 50, cyc, nsp, nrx);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL div1_tx_period: got %0d cycles expected 8", cyc);
        end
    endtask

    task automatic test_frac();
        int cyc, nsp, nrx, total, exp_gap, exp_total;
        baud_int = 13'd3; baud_frac = 4'd8;
        tick_cycle();
        checks++;
        if (s_sp !== 1'b0) begin
            errors++;
            $display("FAIL frac_change_no_tick: got %b expected 0", s_sp);
        end
        total = 0;
        for (int i = 0; i < 10; i++) begin
            wait_ev(0, 50, cyc, nsp, nrx);
            total += cyc;
`ifdef UART_BAUD_FRAC_EN
            exp_gap = (i % 2 == 0) ? 4 : 5;
`else
            exp_gap = 4;
`endif
            checks++;
            if (cyc !== exp_gap) begin
                errors++;
                $display("FAIL frac_gap[%0d]: got %0d expected %0d", i, cyc, exp_gap);
            end
        end
`ifdef UART_BAUD_FRAC_EN
        exp_total = 45;
`else
        exp_total = 40;
`endif
        checks++;
        if (total !== exp_total) begin
            errors++;
            $display("FAIL frac_span_10: got %0d expected %0d", total, exp_total);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, nsp, nrx, exp_gap;
        skip(2);
        PRESETN = 1'b0; baud_int = 13'd0;
        #1;
        checks++;
        if ({rx_sample_pulse, tx_baud_pulse, rx_bit_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_immediate: got %b expected 000",
                     {rx_sample_pulse, tx_baud_pulse, rx_bit_pulse});
        end
        tick_cycle();
        checks++;
        if ({s_sp, s_tx, s_rx} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_held: got %b expected 000", {s_sp, s_tx, s_rx});
        end
        PRESETN = 1'b1; en = 1'b0; baud_int = 13'd3; baud_frac = 4'd8; ovs_sel = 1'b0;
        tick_cycle();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ev(0, 50, cyc, nsp, nrx);
`ifdef UART_BAUD_FRAC_EN
            exp_gap = (i % 2 == 0) ? 4 : 5;
`else
            exp_gap = 4;
`endif
            checks++;
            if (cyc !== exp_gap) begin
                errors++;
                $display("FAIL post_reset_gap[%0d]: got %0d expected %0d", i, cyc, exp_gap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_int_period();
        test_rx_restart();
        test_ovs_change();
        test_en_low();
        test_div_one();
        test_frac();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
